// File: rtl/poly_coeff_input_buffer.sv
// -----------------------------------------------------------------------------
// poly_coeff_input_buffer
// Upstream loader for the polynomial NTT control FSM. Accepts coefficient
// pairs (in1 = poly A, in2 = poly B), reduces each mod Q with one conditional
// subtract, buffers the pairs in a DEPTH-entry FIFO and drains them under a
// valid/ready handshake. One frame is exactly N pairs.
//
// Optional feature macro: IN_RANGE_FLAG_EN
//   defined   -> range_err is a sticky flag set when an accepted input is >= Q
//   undefined -> range_err is tied low and the compare logic is absent
//
// Ports
//   clk, rst            rising-edge clock, async active-high reset
//   in_valid/in_ready   producer handshake; in1/in2 carry the raw pair
//   out_valid/out_ready consumer handshake; out_a/out_b carry the reduced head
//   full, half_full     occupancy == DEPTH, occupancy >= DEPTH/2
//   count               pairs accepted in the current frame
//   frame_done          one-cycle pulse once a full frame has drained
//   range_err           sticky out-of-range indicator (see macro above)
// -----------------------------------------------------------------------------
module poly_coeff_input_buffer #(
  parameter int unsigned W     = 12,
  parameter int unsigned Q     = 3329,
  parameter int unsigned N     = 256,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in1,
  input  logic [W-1:0]             in2,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_a,
  output logic [W-1:0]             out_b,
  output logic                     full,
  output logic                     half_full,
  output logic [$clog2(N+1)-1:0]   count,
  output logic                     frame_done,
  output logic                     range_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [W-1:0] QW = W'(Q);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_mem_a [DEPTH];
  logic [W-1:0]    r_mem_b [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [OW-1:0]   r_occ;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_full;
  logic            r_half_full;
  logic            r_frame_done;

  logic            w_push;
  logic            w_pop;
  logic [OW-1:0]   w_occ_next;
  logic [W-1:0]    w_red_a;
  logic [W-1:0]    w_red_b;

  // Handshakes, next occupancy and single-subtract reduction (inputs < 2*Q)
  always_comb begin
    w_push     = in_valid & r_in_ready;
    w_pop      = r_out_valid & out_ready;
    w_occ_next = r_occ + OW'(w_push) - OW'(w_pop);
    w_red_a    = (in1 >= QW) ? (in1 - QW) : in1;
    w_red_b    = (in2 >= QW) ? (in2 - QW) : in2;
  end

  // FIFO storage, pointers, status flags and frame state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_a[i] <= '0;
        r_mem_b[i] <= '0;
      end
      r_state      <= S_FILL;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
      r_count      <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_full       <= 1'b0;
      r_half_full  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_a[r_wptr] <= w_red_a;
        r_mem_b[r_wptr] <= w_red_b;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end

      r_occ        <= w_occ_next;
      r_out_valid  <= (w_occ_next != '0);
      r_full       <= (w_occ_next == OW'(DEPTH));
      r_half_full  <= (w_occ_next >= OW'(DEPTH / 2));
      r_frame_done <= 1'b0;

      unique case (r_state)
        S_FILL: begin
          // No full pass-through: ready is cleared whenever the FIFO will be full
          r_in_ready <= (w_occ_next != OW'(DEPTH));
          if (w_push) begin
            r_count <= r_count + CW'(1);
            if (r_count == CW'(N - 1)) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_in_ready <= 1'b0;
          if (w_occ_next == '0) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          // FIFO is empty here, so the next frame starts with ready high
          r_count    <= '0;
          r_in_ready <= 1'b1;
          r_state    <= S_FILL;
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

`ifdef IN_RANGE_FLAG_EN
  logic r_range_err;

  // Sticky: only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_range_err <= 1'b0;
    end else if (w_push && ((in1 >= QW) || (in2 >= QW))) begin
      r_range_err <= 1'b1;
    end
  end

  assign range_err = r_range_err;
`else
  assign range_err = 1'b0;
`endif

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_a      = r_mem_a[r_rptr];
  assign out_b      = r_mem_b[r_rptr];
  assign full       = r_full;
  assign half_full  = r_half_full;
  assign count      = r_count;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_poly_coeff_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_poly_coeff_input_buffer
// Self-checking bench: a queue-based reference model of the buffer tracks
// expected occupancy, frame count and done pulse; scenario tasks drive the
// DUT and compare its outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_poly_coeff_input_buffer;

  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int N     = 256;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_a;
  logic [W-1:0]  out_b;
  logic          full;
  logic          half_full;
  logic [8:0]    count;
  logic          frame_done;
  logic          range_err;

  int n_checks = 0;
  int n_errors = 0;

  poly_coeff_input_buffer #(.W(W), .Q(Q), .N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in1        (in1),
    .in2        (in2),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .full       (full),
    .half_full  (half_full),
    .count      (count),
    .frame_done (frame_done),
    .range_err  (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } pair_t;

  pair_t m_q[$];
  int    m_count;
  bit    m_drain;
  bit    m_done;
  bit    m_range;

  function automatic logic [W-1:0] red(input logic [W-1:0] x);
    return W'(int'(x) % Q);
  endfunction

  function automatic bit exp_in_ready();
    return !m_drain && !m_done && (m_q.size() < DEPTH);
  endfunction

  function automatic bit exp_range();
`ifdef IN_RANGE_FLAG_EN
    return m_range;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_clear();
    m_q.delete();
    m_count = 0;
    m_drain = 0;
    m_done  = 0;
    m_range = 0;
  endfunction

  // Applies one clock edge of spec behaviour using the current inputs
  function automatic void model_edge();
    bit    push, pop, was_drain;
    pair_t p, tmp;
    push      = in_valid && exp_in_ready();
    pop       = (m_q.size() != 0) && out_ready;
    was_drain = m_drain;
    if (m_done) begin
      m_done  = 0;
      m_count = 0;
    end else begin
      if (pop) tmp = m_q.pop_front();
      if (push) begin
        p.a = red(in1);
        p.b = red(in2);
        m_q.push_back(p);
        m_count++;
        if (int'(in1) >= Q || int'(in2) >= Q) m_range = 1;
        if (m_count == N) m_drain = 1;
      end
      if (was_drain && pop && m_q.size() == 0) begin
        m_drain = 0;
        m_done  = 1;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    repeat (2) @(negedge clk);
    model_clear();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (half_full !== 1'b0) begin n_errors++; $display("FAIL reset_half_full: got %b expected 0", half_full); end
    n_checks++; if (count !== 9'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (range_err !== 1'b0) begin n_errors++; $display("FAIL reset_range_err: got %b expected 0", range_err); end
    n_checks++; if (out_a !== 12'd0 || out_b !== 12'd0) begin n_errors++; $display("FAIL reset_out_data: got %0d,%0d expected 0,0", out_a, out_b); end
  endtask

  task automatic test_full_frame();
    int pushed = 0, popped = 0, pulses = 0, last_pop = -10;
    bit count_checked = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      in_valid = (pushed < N);
      in1      = W'(pushed + 1);
      in2      = W'(pushed + 257);
      n_checks++; if (in_ready !== exp_in_ready()) begin n_errors++; $display("FAIL frame_in_ready: cycle %0d got %b expected %b", k, in_ready, exp_in_ready()); end
      if (pushed == N && !count_checked) begin
        count_checked = 1;
        n_checks++; if (count !== 9'd256) begin n_errors++; $display("FAIL frame_count_full: got %0d expected 256", count); end
      end
      if (m_q.size() != 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_a !== W'(popped + 1) || out_b !== W'(popped + 257)) begin
          n_errors++; $display("FAIL frame_data: pop %0d got v=%b %0d,%0d expected 1 %0d,%0d", popped, out_valid, out_a, out_b, popped + 1, popped + 257);
        end
        popped++;
        last_pop = k;
      end
      if (frame_done === 1'b1) begin
        pulses++;
        n_checks++; if (k != last_pop + 1 || popped != N) begin n_errors++; $display("FAIL frame_done_timing: at cycle %0d last pop %0d pops %0d expected cycle %0d pops 256", k, last_pop, popped, last_pop + 1); end
      end
      if (in_valid && exp_in_ready()) pushed++;
      cycle();
    end
    in_valid = 1'b0;
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL frame_done_pulses: got %0d expected 1", pulses); end
    n_checks++; if (count !== 9'd0) begin n_errors++; $display("FAIL frame_count_clear: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL frame_idle: got ready=%b valid=%b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reduction();
    apply_reset();
    in_valid = 1'b1; in1 = 12'd3329; in2 = 12'd4095;
    cycle();
    n_checks++; if (range_err !== exp_range()) begin n_errors++; $display("FAIL red_range_err: got %b expected %b", range_err, exp_range()); end
    in1 = 12'd3328; in2 = 12'd0;
    cycle();
    in_valid = 1'b0;
    n_checks++; if (count !== 9'd2) begin n_errors++; $display("FAIL red_count: got %0d expected 2", count); end
    n_checks++; if (out_valid !== 1'b1 || out_a !== 12'd0 || out_b !== 12'd766) begin n_errors++; $display("FAIL red_pair0: got v=%b %0d,%0d expected 1 0,766", out_valid, out_a, out_b); end
    out_ready = 1'b1;
    cycle();
    n_checks++; if (out_valid !== 1'b1 || out_a !== 12'd3328 || out_b !== 12'd0) begin n_errors++; $display("FAIL red_pair1: got v=%b %0d,%0d expected 1 3328,0", out_valid, out_a, out_b); end
    cycle();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL red_empty: got %b expected 0", out_valid); end
    n_checks++; if (range_err !== exp_range()) begin n_errors++; $display("FAIL red_range_sticky: got %b expected %b", range_err, exp_range()); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] va [17];
    logic [W-1:0] vb [17];
    int idx = 0, popped = 0;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      va[i] = W'($urandom_range(0, 4095));
      vb[i] = W'($urandom_range(0, 4095));
    end
    for (int k = 0; k < 80 && (popped < 17 || idx < 17); k++) begin
      if (idx < 17) begin in_valid = 1'b1; in1 = va[idx]; in2 = vb[idx]; end
      else in_valid = 1'b0;
      if (k == 20) out_ready = 1'b1;
      if (!out_ready) begin
        n_checks++;
        if (half_full !== (idx >= 8) || full !== (idx >= 16) || in_ready !== (idx < 16)) begin
          n_errors++; $display("FAIL bp_flags: after %0d pushes got hf=%b f=%b rdy=%b expected %b %b %b", idx, half_full, full, in_ready, idx >= 8, idx >= 16, idx < 16);
        end
      end
      if (out_ready && m_q.size() != 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_a !== red(va[popped]) || out_b !== red(vb[popped])) begin
          n_errors++; $display("FAIL bp_order: pop %0d got v=%b %0d,%0d expected 1 %0d,%0d", popped, out_valid, out_a, out_b, red(va[popped]), red(vb[popped]));
        end
        popped++;
      end
      if (in_valid && exp_in_ready()) idx++;
      cycle();
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || full !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_final: got v=%b f=%b rdy=%b expected 0 0 1", out_valid, full, in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_concurrency();
    pair_t sent[$];
    pair_t p;
    int popped = 0;
    apply_reset();
    for (int k = 0; k < 15 + 30 && popped < 15; k++) begin
      p.a = W'($urandom_range(0, 4095));
      p.b = W'($urandom_range(0, 4095));
      in1 = p.a; in2 = p.b;
      in_valid  = (sent.size() < 15);
      out_ready = (k >= 5);
      if (k >= 5 && k < 15) begin
        n_checks++; if (out_valid !== 1'b1 || half_full !== 1'b0 || full !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL conc_flags: cycle %0d got v=%b hf=%b f=%b rdy=%b expected 1 0 0 1", k, out_valid, half_full, full, in_ready); end
      end
      if (out_ready && m_q.size() != 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_a !== red(sent[popped].a) || out_b !== red(sent[popped].b)) begin
          n_errors++; $display("FAIL conc_order: pop %0d got %0d,%0d expected %0d,%0d", popped, out_a, out_b, red(sent[popped].a), red(sent[popped].b));
        end
        popped++;
      end
      if (in_valid && exp_in_ready()) sent.push_back(p);
      cycle();
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || count !== 9'd15) begin n_errors++; $display("FAIL conc_drained: got v=%b count=%0d expected 0 15", out_valid, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 1600; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in1       = W'($urandom_range(0, 4095));
      in2       = W'($urandom_range(0, 4095));
      n_checks++;
      if (in_ready !== exp_in_ready() || out_valid !== (m_q.size() != 0) || full !== (m_q.size() == DEPTH) ||
          half_full !== (m_q.size() >= DEPTH / 2) || count !== 9'(m_count) || frame_done !== m_done || range_err !== exp_range()) begin
        n_errors++;
        $display("FAIL rand_status: cycle %0d got rdy=%b v=%b f=%b hf=%b cnt=%0d fd=%b re=%b expected %b %b %b %b %0d %b %b",
                 k, in_ready, out_valid, full, half_full, count, frame_done, range_err,
                 exp_in_ready(), m_q.size() != 0, m_q.size() == DEPTH, m_q.size() >= DEPTH / 2, m_count, m_done, exp_range());
      end
      if (m_q.size() != 0) begin
        n_checks++;
        if (out_a !== m_q[0].a || out_b !== m_q[0].b) begin n_errors++; $display("FAIL rand_data: cycle %0d got %0d,%0d expected %0d,%0d", k, out_a, out_b, m_q[0].a, m_q[0].b); end
      end
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] fa, fb;
    apply_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 300 && m_count < 100; k++) begin
      in1 = W'($urandom_range(0, 4095));
      in2 = W'($urandom_range(0, 4095));
      cycle();
    end
    n_checks++; if (count !== 9'd100) begin n_errors++; $display("FAIL mid_count_before: got %0d expected 100", count); end
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 9'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || full !== 1'b0 || half_full !== 1'b0) begin
      n_errors++; $display("FAIL mid_async_clear: got cnt=%0d v=%b rdy=%b f=%b hf=%b expected 0 0 1 0 0", count, out_valid, in_ready, full, half_full);
    end
    @(negedge clk);
    model_clear();
    rst = 1'b0;
    fa = 12'd4000; fb = 12'd17;
    in1 = fa; in2 = fb; in_valid = 1'b1;
    cycle();
    in1 = 12'd5; in2 = 12'd6;
    cycle();
    in_valid = 1'b0;
    n_checks++; if (count !== 9'd2) begin n_errors++; $display("FAIL mid_new_count: got %0d expected 2", count); end
    n_checks++; if (out_valid !== 1'b1 || out_a !== 12'd671 || out_b !== 12'd17) begin n_errors++; $display("FAIL mid_new_head: got v=%b %0d,%0d expected 1 671,17", out_valid, out_a, out_b); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_reduction();
    test_backpressure();
    test_concurrency();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
